// File: rtl/lcd_bus_pkg.sv
// Shared encodings and timing minimums for the 8080-style panel write engine.
package lcd_bus_pkg;

   typedef enum logic [2:0] {
      ST_RST_LO = 3'd0,
      ST_RST_WT = 3'd1,
      ST_IDLE   = 3'd2,
      ST_SETUP  = 3'd3,
      ST_WR_LO  = 3'd4,
      ST_WR_HI  = 3'd5
   } lcd_state_t;

   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_DATA = 1'b1;

   localparam int MIN_T_SETUP    = 1;
   localparam int MIN_T_WR_LOW   = 1;
   localparam int MIN_T_WR_HIGH  = 1;
   localparam int MIN_RST_LOW    = 1;
   localparam int MIN_RST_WAIT   = 1;
   localparam int MIN_FIFO_DEPTH = 2;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_bus_writer_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; the head word is read from registered
// storage, so a word pushed on an edge becomes visible only after that edge.
module sync_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_n_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_level = r_wr_ptr - r_rd_ptr;
   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   // A pop cannot free a slot for a push on the same edge: full blocks the push.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/lcd_bus_writer.sv
// Panel reset sequencing plus a FIFO-fed 8080 write strobe generator with
// programmable setup, WR-low and WR-high widths.
module lcd_bus_writer
   import lcd_bus_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int T_SETUP    = 1,
   parameter int T_WR_LOW   = 2,
   parameter int T_WR_HIGH  = 2,
   parameter int RST_LOW    = 10,
   parameter int RST_WAIT   = 20
) (
   input  logic                          i_clk,
   input  logic                          i_n_rst,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic                          i_in_rs,
   input  logic [DATA_W-1:0]             i_in_data,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_busy,
   output logic [DATA_W-1:0]             o_lcd_data,
   output logic                          o_lcd_rs,
   output logic                          o_lcd_wr,
   output logic                          o_lcd_rd,
   output logic                          o_lcd_cs,
   output logic                          o_lcd_rst,
   output lcd_state_t                    o_dbg_state
);

   localparam int T_MAX = max_of(max_of(max_of(T_SETUP, T_WR_LOW), max_of(T_WR_HIGH, RST_LOW)), RST_WAIT);
   localparam int CW    = $clog2(T_MAX) + 1;

   if (T_SETUP < MIN_T_SETUP) begin : g_chk_setup
      $error("T_SETUP below minimum");
   end
   if (T_WR_LOW < MIN_T_WR_LOW) begin : g_chk_wr_low
      $error("T_WR_LOW below minimum");
   end
   if (T_WR_HIGH < MIN_T_WR_HIGH) begin : g_chk_wr_high
      $error("T_WR_HIGH below minimum");
   end
   if (RST_LOW < MIN_RST_LOW || RST_WAIT < MIN_RST_WAIT) begin : g_chk_rst
      $error("RST_LOW/RST_WAIT below minimum");
   end
   if (FIFO_DEPTH < MIN_FIFO_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("FIFO_DEPTH must be a power of two, at least 2");
   end
   if (DATA_W != 8 && DATA_W != 16) begin : g_chk_width
      $error("DATA_W must be 8 or 16");
   end

   lcd_state_t        r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_lcd_rst;
   logic              r_lcd_cs;
   logic              r_lcd_wr;
   logic              r_lcd_rd;
   logic              r_lcd_rs;
   logic [DATA_W-1:0] r_lcd_data;

   logic [DATA_W:0]   w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_cnt_done;
   logic              w_load;

   sync_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_n_rst (i_n_rst),
      .i_push  (i_in_valid),
      .i_wdata ({i_in_rs, i_in_data}),
      .i_pop   (w_load),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (o_fifo_level)
   );

   assign w_cnt_done = (r_cnt == '0);

   // A word is popped from IDLE, or straight out of RST_WT / WR_HI at their last cycle.
   always_comb begin
      w_load = 1'b0;
      if (!w_empty) begin
         case (r_state)
            ST_IDLE:             w_load = 1'b1;
            ST_RST_WT, ST_WR_HI: w_load = w_cnt_done;
            default:             w_load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         r_state    <= ST_RST_LO;
         r_cnt      <= CW'(RST_LOW);
         r_lcd_rst  <= 1'b0;
         r_lcd_cs   <= 1'b1;
         r_lcd_wr   <= 1'b1;
         r_lcd_rd   <= 1'b1;
         r_lcd_rs   <= RS_CMD;
         r_lcd_data <= '0;
      end else begin
         r_lcd_rd <= 1'b1;
         if (w_load) begin
            r_state    <= ST_SETUP;
            r_cnt      <= CW'(T_SETUP - 1);
            r_lcd_cs   <= 1'b0;
            r_lcd_rs   <= w_head[DATA_W];
            r_lcd_data <= w_head[DATA_W-1:0];
         end else begin
            case (r_state)
               ST_RST_LO: begin
                  if (w_cnt_done) begin
                     r_state   <= ST_RST_WT;
                     r_cnt     <= CW'(RST_WAIT - 1);
                     r_lcd_rst <= 1'b1;
                  end else r_cnt <= r_cnt - CW'(1);
               end
               ST_RST_WT: begin
                  if (w_cnt_done) r_state <= ST_IDLE;
                  else            r_cnt   <= r_cnt - CW'(1);
               end
               ST_IDLE: begin
                  r_lcd_cs <= 1'b1;
               end
               ST_SETUP: begin
                  if (w_cnt_done) begin
                     r_state  <= ST_WR_LO;
                     r_cnt    <= CW'(T_WR_LOW - 1);
                     r_lcd_wr <= 1'b0;
                  end else r_cnt <= r_cnt - CW'(1);
               end
               ST_WR_LO: begin
                  if (w_cnt_done) begin
                     r_state  <= ST_WR_HI;
                     r_cnt    <= CW'(T_WR_HIGH - 1);
                     r_lcd_wr <= 1'b1;
                  end else r_cnt <= r_cnt - CW'(1);
               end
               ST_WR_HI: begin
                  if (w_cnt_done) begin
                     r_state  <= ST_IDLE;
                     r_lcd_cs <= 1'b1;
                  end else r_cnt <= r_cnt - CW'(1);
               end
               default: begin
                  r_state   <= ST_RST_LO;
                  r_cnt     <= CW'(RST_LOW);
                  r_lcd_rst <= 1'b0;
                  r_lcd_cs  <= 1'b1;
                  r_lcd_wr  <= 1'b1;
               end
            endcase
         end
      end
   end

   assign o_in_ready  = !w_full;
   assign o_busy      = (r_state != ST_IDLE) || !w_empty;
   assign o_lcd_data  = r_lcd_data;
   assign o_lcd_rs    = r_lcd_rs;
   assign o_lcd_wr    = r_lcd_wr;
   assign o_lcd_rd    = r_lcd_rd;
   assign o_lcd_cs    = r_lcd_cs;
   assign o_lcd_rst   = r_lcd_rst;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Self-checking bench: default-parameter instance plus an 8-bit, slow-strobe instance,
// each with a word scoreboard and a cycle-level model of the expected bus waveform.
module tb_lcd_bus_writer;
   import lcd_bus_pkg::*;

   localparam int DW = 16, DEPTH = 16, TS = 1, TL = 2, TH = 2, RL = 10, RW = 20;
   localparam int P  = TS + TL + TH;
   localparam int DW8 = 8, DEPTH8 = 4, TS8 = 3, TL8 = 4, TH8 = 1, RL8 = 3, RW8 = 4;
   localparam int P8 = TS8 + TL8 + TH8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_tests = 0;
   int n_fail  = 0;

   // instance A: defaults
   logic          n_rst, in_valid, in_ready, in_rs, busy;
   logic [DW-1:0] in_data, lcd_data;
   logic          lcd_rs, lcd_wr, lcd_rd, lcd_cs, lcd_rst;
   logic [4:0]    fifo_level;
   lcd_state_t    dbg_state;

   // instance B: 8-bit bus, long setup/WR-low, short WR-high
   logic           n_rst_b, in_valid_b, in_ready_b, in_rs_b, busy_b;
   logic [DW8-1:0] in_data_b, lcd_data_b;
   logic           lcd_rs_b, lcd_wr_b, lcd_rd_b, lcd_cs_b, lcd_rst_b;
   logic [2:0]     fifo_level_b;
   lcd_state_t     dbg_state_b;

   lcd_bus_writer dut (
      .i_clk(clk), .i_n_rst(n_rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_rs(in_rs), .i_in_data(in_data), .o_fifo_level(fifo_level), .o_busy(busy),
      .o_lcd_data(lcd_data), .o_lcd_rs(lcd_rs), .o_lcd_wr(lcd_wr), .o_lcd_rd(lcd_rd),
      .o_lcd_cs(lcd_cs), .o_lcd_rst(lcd_rst), .o_dbg_state(dbg_state)
   );

   lcd_bus_writer #(
      .DATA_W(DW8), .FIFO_DEPTH(DEPTH8), .T_SETUP(TS8), .T_WR_LOW(TL8),
      .T_WR_HIGH(TH8), .RST_LOW(RL8), .RST_WAIT(RW8)
   ) dut_b (
      .i_clk(clk), .i_n_rst(n_rst_b), .i_in_valid(in_valid_b), .o_in_ready(in_ready_b),
      .i_in_rs(in_rs_b), .i_in_data(in_data_b), .o_fifo_level(fifo_level_b), .o_busy(busy_b),
      .o_lcd_data(lcd_data_b), .o_lcd_rs(lcd_rs_b), .o_lcd_wr(lcd_wr_b), .o_lcd_rd(lcd_rd_b),
      .o_lcd_cs(lcd_cs_b), .o_lcd_rst(lcd_rst_b), .o_dbg_state(dbg_state_b)
   );

   // Scoreboards: words enter on acceptance, leave on each observed WR falling edge.
   logic [DW:0]  exp_q[$];
   logic [DW8:0] exp_b_q[$];
   int           wr_cnt = 0, wr_cnt_b = 0;
   logic         prev_wr = 1'b1, prev_wr_b = 1'b1;
   logic [DW:0]  cap_a, exp_a;
   logic [DW8:0] cap_b, exp_b;

   always begin
      @(posedge clk); #2;
      if (prev_wr && !lcd_wr) begin
         wr_cnt++;
         cap_a = {lcd_rs, lcd_data};
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_word_a: got %h, required no write (queue empty)", cap_a);
         end else begin
            exp_a = exp_q.pop_front();
            if (cap_a !== exp_a) begin
               n_fail++;
               $display("FAIL wr_word_a: got %h, required %h", cap_a, exp_a);
            end
         end
      end else if (!lcd_wr) begin
         n_tests++;
         if ({lcd_rs, lcd_data} !== cap_a) begin
            n_fail++;
            $display("FAIL wr_stable_a: got %h, required %h", {lcd_rs, lcd_data}, cap_a);
         end
      end
      prev_wr = lcd_wr;
   end

   always begin
      @(posedge clk); #2;
      if (prev_wr_b && !lcd_wr_b) begin
         wr_cnt_b++;
         cap_b = {lcd_rs_b, lcd_data_b};
         n_tests++;
         if (exp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL wr_word_b: got %h, required no write (queue empty)", cap_b);
         end else begin
            exp_b = exp_b_q.pop_front();
            if (cap_b !== exp_b) begin
               n_fail++;
               $display("FAIL wr_word_b: got %h, required %h", cap_b, exp_b);
            end
         end
      end else if (!lcd_wr_b) begin
         n_tests++;
         if ({lcd_rs_b, lcd_data_b} !== cap_b) begin
            n_fail++;
            $display("FAIL wr_stable_b: got %h, required %h", {lcd_rs_b, lcd_data_b}, cap_b);
         end
      end
      prev_wr_b = lcd_wr_b;
   end

   // Expected {cs, wr}, j edges after the first of n words accepted on consecutive edges into an idle engine.
   function automatic logic [1:0] bus_model(input int j, input int n, input int ts, input int tl, input int th);
      int   p;
      logic cs;
      logic wr;
      p  = ts + tl + th;
      cs = 1'b1;
      wr = 1'b1;
      if (j >= 1 && j < 1 + n * p) cs = 1'b0;
      for (int w = 0; w < n; w++)
         if (j >= 1 + ts + w * p && j < 1 + ts + w * p + tl) wr = 1'b0;
      return {cs, wr};
   endfunction

   // After reset release: lcd_rst rises RST_LOW edges after the first, busy clears RST_WAIT later, no CS activity.
   task automatic check_reset_seq(input string tag, input int cycles);
      logic exp_rst, exp_busy;
      for (int k = 1; k <= cycles; k++) begin
         @(negedge clk);
         exp_rst  = (k >= 1 + RL);
         exp_busy = (k < 1 + RL + RW);
         n_tests++;
         if (lcd_rst !== exp_rst || lcd_cs !== 1'b1 || lcd_wr !== 1'b1 || busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s k=%0d: got rst/cs/wr/busy=%b%b%b%b, required %b11%b",
                     tag, k, lcd_rst, lcd_cs, lcd_wr, busy, exp_rst, exp_busy);
         end
      end
   endtask

   task automatic wait_drain_a(input string tag, input int budget);
      int t = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (t >= budget) begin
         n_fail++;
         $display("FAIL %s drain: got busy=%b queued=%0d after %0d cycles, required idle", tag, busy, exp_q.size(), t);
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b1; n_rst_b = 1'b1;
      in_valid = 1'b0; in_rs = RS_CMD; in_data = '0;
      in_valid_b = 1'b0; in_rs_b = RS_CMD; in_data_b = '0;
      #1;
      n_rst = 1'b0; n_rst_b = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({lcd_rst, lcd_cs, lcd_wr, lcd_rd, lcd_rs, busy, in_ready} !== 7'b0111011) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rst,cs,wr,rd,rs,busy,ready=%b, required 0111011",
                  {lcd_rst, lcd_cs, lcd_wr, lcd_rd, lcd_rs, busy, in_ready});
      end
      n_tests++;
      if (lcd_data !== 16'h0000 || fifo_level !== 5'd0) begin
         n_fail++;
         $display("FAIL reset_data: got data=%h level=%0d, required 0000 and 0", lcd_data, fifo_level);
      end
      n_rst = 1'b1;
      n_rst_b = 1'b1;
      check_reset_seq("reset_seq", 40);
   endtask

   task automatic test_single();
      logic [1:0] m;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b, required 1", in_ready);
      end
      in_valid = 1'b1; in_rs = RS_CMD; in_data = 16'h0022;
      exp_q.push_back({RS_CMD, 16'h0022});
      for (int j = 0; j <= 10; j++) begin
         @(negedge clk);
         in_valid = 1'b0;
         m = bus_model(j, 1, TS, TL, TH);
         n_tests++;
         if ({lcd_cs, lcd_wr, busy} !== {m, (j < 1 + P) ? 1'b1 : 1'b0}) begin
            n_fail++;
            $display("FAIL single_bus j=%0d: got cs,wr,busy=%b, required %b%b", j, {lcd_cs, lcd_wr, busy}, m, (j < 1 + P));
         end
         if (j == 1) begin
            n_tests++;
            if ({lcd_rs, lcd_data} !== {RS_CMD, 16'h0022}) begin
               n_fail++;
               $display("FAIL single_latency: got %h, required %h", {lcd_rs, lcd_data}, {RS_CMD, 16'h0022});
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW:0] w[3];
      logic [1:0]  m;
      w[0] = {RS_CMD, 16'h0002};
      w[1] = {RS_DATA, 16'h00EF};
      w[2] = {RS_DATA, 16'h1234};
      @(negedge clk);
      {in_rs, in_data} = w[0];
      in_valid = 1'b1;
      exp_q.push_back(w[0]);
      for (int j = 0; j <= 20; j++) begin
         @(negedge clk);
         if (j < 2) begin
            {in_rs, in_data} = w[j + 1];
            exp_q.push_back(w[j + 1]);
         end else in_valid = 1'b0;
         m = bus_model(j, 3, TS, TL, TH);
         n_tests++;
         if ({lcd_cs, lcd_wr} !== m) begin
            n_fail++;
            $display("FAIL burst_bus j=%0d: got cs,wr=%b, required %b", j, {lcd_cs, lcd_wr}, m);
         end
      end
      wait_drain_a("burst", 50);
   endtask

   task automatic test_fill();
      logic [DW:0] words[20];
      int   acc = 0, base, k17 = -1;
      logic pend = 1'b0, pend_ready = 1'b0;
      for (int i = 0; i < 20; i++) words[i] = {1'($urandom_range(0, 1)), 16'($urandom)};
      n_rst = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      base = wr_cnt;
      repeat (12) @(negedge clk);
      {in_rs, in_data} = words[0]; in_valid = 1'b1; pend = 1'b1; pend_ready = in_ready;
      for (int k = 13; k <= 400 && acc < 20; k++) begin
         @(negedge clk);
         if (pend && pend_ready) begin
            exp_q.push_back(words[acc]);
            acc++;
            if (acc == 17) k17 = k;
         end
         if (k <= RL + RW) begin
            n_tests++;
            if (fifo_level !== 5'(acc) || in_ready !== (acc < DEPTH)) begin
               n_fail++;
               $display("FAIL fill_level k=%0d: got level=%0d ready=%b, required %0d %b", k, fifo_level, in_ready, acc, (acc < DEPTH));
            end
         end
         if (acc < 20) begin
            {in_rs, in_data} = words[acc]; in_valid = 1'b1; pend = 1'b1; pend_ready = in_ready;
         end else begin
            in_valid = 1'b0; pend = 1'b0;
         end
      end
      n_tests++;
      if (acc != 20 || k17 != RL + RW + 2) begin
         n_fail++;
         $display("FAIL fill_accept: got accepted=%0d word17_at=%0d, required 20 and %0d", acc, k17, RL + RW + 2);
      end
      wait_drain_a("fill", 400);
      n_tests++;
      if (wr_cnt - base != 20) begin
         n_fail++;
         $display("FAIL fill_count: got %0d writes, required 20", wr_cnt - base);
      end
   endtask

   task automatic test_params8();
      logic [DW8:0]  w[4];
      logic [DW8-1:0] prev, d;
      logic [DW8:0]  last;
      logic [1:0]    m;
      logic          chg, chg_exp;
      int            t = 0;
      prev = 8'h00;
      for (int i = 0; i < 4; i++) begin
         d = prev ^ 8'($urandom_range(1, 255));
         w[i] = {1'($urandom_range(0, 1)), d};
         prev = d;
      end
      last = {RS_CMD, 8'h00};
      @(negedge clk);
      {in_rs_b, in_data_b} = w[0]; in_valid_b = 1'b1;
      exp_b_q.push_back(w[0]);
      for (int j = 0; j <= 4 * P8 + 4; j++) begin
         @(negedge clk);
         if (j < 3) begin
            {in_rs_b, in_data_b} = w[j + 1];
            exp_b_q.push_back(w[j + 1]);
         end else in_valid_b = 1'b0;
         m = bus_model(j, 4, TS8, TL8, TH8);
         n_tests++;
         if ({lcd_cs_b, lcd_wr_b} !== m) begin
            n_fail++;
            $display("FAIL p8_bus j=%0d: got cs,wr=%b, required %b", j, {lcd_cs_b, lcd_wr_b}, m);
         end
         chg     = ({lcd_rs_b, lcd_data_b} !== last);
         chg_exp = (j >= 1) && ((j - 1) % P8 == 0) && ((j - 1) / P8 < 4);
         n_tests++;
         if (chg !== chg_exp) begin
            n_fail++;
            $display("FAIL p8_data_change j=%0d: got change=%b, required %b", j, chg, chg_exp);
         end
         last = {lcd_rs_b, lcd_data_b};
      end
      while ((busy_b !== 1'b0 || exp_b_q.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (t >= 100 || wr_cnt_b != 4) begin
         n_fail++;
         $display("FAIL p8_drain: got writes=%0d queued=%0d, required 4 and 0", wr_cnt_b, exp_b_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [DW:0] w[4];
      int base, sent = 0;
      for (int i = 0; i < 4; i++) w[i] = {1'($urandom_range(0, 1)), 16'($urandom)};
      base = wr_cnt;
      for (int t = 0; t < 100 && wr_cnt < base + 2; t++) begin
         @(negedge clk);
         if (sent < 4) begin
            {in_rs, in_data} = w[sent]; in_valid = 1'b1;
            exp_q.push_back(w[sent]);
            sent++;
         end else in_valid = 1'b0;
      end
      n_tests++;
      if (wr_cnt != base + 2 || lcd_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reach: got writes=%0d wr=%b, required %0d and 0", wr_cnt - base, lcd_wr, 2);
      end
      n_rst = 1'b0;
      in_valid = 1'b0;
      #1;
      n_tests++;
      if ({lcd_wr, lcd_cs, lcd_rst, busy, in_ready} !== 5'b11011 || fifo_level !== 5'd0) begin
         n_fail++;
         $display("FAIL mid_async: got wr,cs,rst,busy,ready=%b level=%0d, required 11011 and 0",
                  {lcd_wr, lcd_cs, lcd_rst, busy, in_ready}, fifo_level);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      check_reset_seq("mid_replay", 45);
      n_tests++;
      if (wr_cnt != base + 2) begin
         n_fail++;
         $display("FAIL mid_no_more: got %0d writes, required 2", wr_cnt - base);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fill();
      test_params8();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
